// File: rtl/icache_mem_responder_if.sv
// Cache-to-memory miss/writeback link: single-cycle request strobe and one-cycle response strobe.
// No backpressure; the cache issues one request and waits for mem_data_ready before issuing the next.
interface icache_mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [63:0]       mem_req_data;
  logic              mem_data_ready;
  logic [31:0]       mem_data_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    input  mem_data_ready, mem_data_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    output mem_data_ready, mem_data_data
  );
endinterface

// File: rtl/icache_mem_responder.sv
// Fixed-latency (LATENCY cycles) 16-bit-word backing store: 2-word reads, 4-word line writes; requests seen while busy are dropped.
// PROTO_CHK_EN adds a sticky proto_err output flagging stray requests and X/Z request fields.
module icache_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_mem_responder_if.slave mem_if
`ifdef PROTO_CHK_EN
  ,
  output logic                 proto_err
`endif
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              commit;
  logic              mem_we;
  logic              cmt_rw;
  logic [ADDR_W-1:0] cmt_addr;
  logic [63:0]       cmt_data;
  logic [ADDR_W-3:0] cmt_line;
  logic [1:0]        off_lo, off_hi;

  logic [15:0]       mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (commit) begin
        rdata_q <= rdata_d;
      end
    end
  end

  // RESP accepts a new request exactly like IDLE so the cache can re-issue on ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (mem_if.mem_req_valid) begin
          accept  = 1'b1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_LOAD;
          rw_d    = mem_if.mem_req_rw;
          addr_d  = mem_if.mem_req_addr;
          wdata_d = mem_if.mem_req_data;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array access happens on the edge entering RESP; with LATENCY==1 that is the accept edge itself.
  always_comb begin
    if (LATENCY == 1) begin
      commit   = accept;
      cmt_rw   = mem_if.mem_req_rw;
      cmt_addr = mem_if.mem_req_addr;
      cmt_data = mem_if.mem_req_data;
    end else begin
      commit   = (state_q == WAIT) && (cnt_q == CNT_ONE);
      cmt_rw   = rw_q;
      cmt_addr = addr_q;
      cmt_data = wdata_q;
    end
    cmt_line = cmt_addr[ADDR_W-1:2];
    off_lo   = cmt_addr[1:0];
    off_hi   = off_lo + 2'd1;
    mem_we   = commit && cmt_rw && rst_n;
    rdata_d  = cmt_rw ? 32'd0 : {mem_q[{cmt_line, off_hi}], mem_q[{cmt_line, off_lo}]};
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[{cmt_line, 2'(i)}] <= cmt_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    mem_if.mem_data_ready = (state_q == RESP);
    mem_if.mem_data_data  = (state_q == RESP) ? rdata_q : 32'd0;
  end

`ifdef PROTO_CHK_EN
  logic proto_err_q, proto_err_d;
  logic stray_req, req_unknown;

  assign stray_req = mem_if.mem_req_valid && (state_q == WAIT);
`ifndef SYNTHESIS
  assign req_unknown = (mem_if.mem_req_valid === 1'b1) &&
                       $isunknown({mem_if.mem_req_rw, mem_if.mem_req_addr});
`else
  assign req_unknown = 1'b0;
`endif

  always_comb begin
    proto_err_d = proto_err_q || stray_req || req_unknown;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && (stray_req || req_unknown)) begin
      $error("icache_mem_responder: protocol violation (stray=%0b unknown=%0b)", stray_req, req_unknown);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_icache_mem_responder.sv
// Drives a LATENCY=4 and a LATENCY=1 responder; a transaction-level model predicts every output cycle.
module tb_icache_mem_responder;

  logic clk;
  logic rst4_n, rst1_n;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;

  icache_mem_responder_if #(.ADDR_W(16)) if4 ();
  icache_mem_responder_if #(.ADDR_W(16)) if1 ();

`ifdef PROTO_CHK_EN
  logic perr4, perr1;
`endif

  icache_mem_responder #(.ADDR_W(16), .LATENCY(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst4_n),
    .mem_if (if4.slave)
`ifdef PROTO_CHK_EN
    ,
    .proto_err (perr4)
`endif
  );

  icache_mem_responder #(.ADDR_W(16), .LATENCY(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst1_n),
    .mem_if (if1.slave)
`ifdef PROTO_CHK_EN
    ,
    .proto_err (perr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          pend;
    int unsigned rc;
    bit          rw;
    logic [15:0] addr;
    logic [63:0] data;
  } pend_t;

  pend_t       pm [2];
  logic [15:0] mm [int];
  int          lat [2] = '{4, 1};

  function automatic int key(input int d, input logic [15:0] a);
    return d * 65536 + int'(a);
  endfunction

  initial begin
    pm[0].pend = 0;
    pm[1].pend = 0;
  end

  // Cycle c = period sampled at negedge c; a request valid in cycle c responds in cycle c+LATENCY.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit          rst_lo, v, rw, er, known;
      logic [15:0] a, lo_a, hi_a;
      logic [63:0] wd;
      logic [31:0] ed;
      logic        rdy;
      logic [31:0] dat;
      rst_lo = (d == 0) ? !rst4_n : !rst1_n;
      v      = (d == 0) ? if4.mem_req_valid : if1.mem_req_valid;
      rw     = (d == 0) ? if4.mem_req_rw : if1.mem_req_rw;
      a      = (d == 0) ? if4.mem_req_addr : if1.mem_req_addr;
      wd     = (d == 0) ? if4.mem_req_data : if1.mem_req_data;
      rdy    = (d == 0) ? if4.mem_data_ready : if1.mem_data_ready;
      dat    = (d == 0) ? if4.mem_data_data : if1.mem_data_data;
      er     = 0;
      ed     = 32'd0;
      known  = 1;
      if (pm[d].pend && pm[d].rc == cyc) begin
        pm[d].pend = 0;
        er = !rst_lo;
        if (pm[d].rw) begin
          for (int i = 0; i < 4; i++)
            mm[key(d, {pm[d].addr[15:2], 2'(i)})] = pm[d].data[16*i +: 16];
        end else begin
          lo_a  = pm[d].addr;
          hi_a  = {pm[d].addr[15:2], 2'(pm[d].addr[1:0] + 2'd1)};
          known = mm.exists(key(d, lo_a)) && mm.exists(key(d, hi_a));
          if (known) ed = {mm[key(d, hi_a)], mm[key(d, lo_a)]};
        end
      end
      if (rst_lo) begin
        pm[d].pend = 0;
        ed = 32'd0;
      end
      check((d == 0) ? "model_rdy_L4" : "model_rdy_L1", 64'(rdy), 64'(er));
      if (!er || known)
        check((d == 0) ? "model_dat_L4" : "model_dat_L1", 64'(dat), 64'(er ? ed : 32'd0));
      if (!rst_lo && v && !pm[d].pend) begin
        pm[d].pend = 1;
        pm[d].rc   = cyc + lat[d];
        pm[d].rw   = rw;
        pm[d].addr = a;
        pm[d].data = wd;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input bit m4, input bit m1, input bit rw, input logic [15:0] a, input logic [63:0] d);
    if4.mem_req_valid = m4;
    if4.mem_req_rw    = rw;
    if4.mem_req_addr  = a;
    if4.mem_req_data  = d;
    if1.mem_req_valid = m1;
    if1.mem_req_rw    = rw;
    if1.mem_req_addr  = a;
    if1.mem_req_data  = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue to both DUTs in the current cycle, optionally checking the L4 response due now; ends at the start of its own response cycle.
  task automatic send(input bit rw, input logic [15:0] a, input logic [63:0] d,
                      input bit chk, input logic [31:0] exp, input string nm);
    drv(1'b1, 1'b1, rw, a, d);
    if (chk) begin
      @(negedge clk);
      check({nm, "_rdy"}, 64'(if4.mem_data_ready), 64'h1);
      check({nm, "_dat"}, 64'(if4.mem_data_data), 64'(exp));
    end
    step();
    idle();
    step();
    step();
    step();
  endtask

  task automatic finish_resp(input logic [31:0] exp, input string nm);
    @(negedge clk);
    check({nm, "_rdy"}, 64'(if4.mem_data_ready), 64'h1);
    check({nm, "_dat"}, 64'(if4.mem_data_data), 64'(exp));
    step();
  endtask

  localparam logic [63:0] LINE4 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] ALL_A = {4{16'hAAAA}};

  initial begin
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdy4", 64'(if4.mem_data_ready), 64'h0);
    check("reset_dat4", 64'(if4.mem_data_data), 64'h0);
    check("reset_rdy1", 64'(if1.mem_data_ready), 64'h0);
    check("reset_dat1", 64'(if1.mem_data_data), 64'h0);
    step();
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    step();

    // Preload lines 0..15; line 4 (addr 0x0010) carries the known pattern.
    for (int i = 0; i < 16; i++)
      send(1'b1, 16'(i * 4), (i == 4) ? LINE4 : {$urandom, $urandom}, i > 0, 32'h0, "init_wr");
    send(1'b0, 16'h0010, 64'h0, 1'b1, 32'h0, "last_wr");
    send(1'b0, 16'h0011, 64'h0, 1'b1, 32'h2222_1111, "rd_0010");
    send(1'b0, 16'h0013, 64'h0, 1'b1, 32'h3333_2222, "b2b_0011");
    send(1'b0, 16'h0012, 64'h0, 1'b1, 32'h1111_4444, "wrap_0013");
    finish_resp(32'h4444_3333, "wrap_0012");

    // Stray request two cycles into WAIT must be dropped.
    drv(1'b1, 1'b1, 1'b0, 16'h0010, 64'h0);
    step();
    idle();
    step();
    drv(1'b1, 1'b1, 1'b0, 16'h0020, 64'h0);
    step();
    idle();
    step();
    @(negedge clk);
    check("stray_first_rdy", 64'(if4.mem_data_ready), 64'h1);
    check("stray_first_dat", 64'(if4.mem_data_data), 64'h2222_1111);
    step();
    @(negedge clk);
    check("stray_dropped", 64'(if4.mem_data_ready), 64'h0);
`ifdef PROTO_CHK_EN
    check("proto_err4_set", 64'(perr4), 64'h1);
    check("proto_err1_clear", 64'(perr1), 64'h0);
    repeat (3) step();
    check("proto_err4_sticky", 64'(perr4), 64'h1);
`endif
    step();

    // Asynchronous reset during a response cycle clears outputs immediately.
    drv(1'b1, 1'b1, 1'b0, 16'h0012, 64'h0);
    step();
    idle();
    repeat (3) step();
    check("pre_rst_rdy", 64'(if4.mem_data_ready), 64'h1);
    #1;
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    #1;
    check("async_rst_rdy4", 64'(if4.mem_data_ready), 64'h0);
    check("async_rst_dat4", 64'(if4.mem_data_data), 64'h0);
    check("async_rst_rdy1", 64'(if1.mem_data_ready), 64'h0);
    check("async_rst_dat1", 64'(if1.mem_data_data), 64'h0);
    step();
    rst4_n = 1'b1;
    rst1_n = 1'b1;
`ifdef PROTO_CHK_EN
    check("proto_err4_reset", 64'(perr4), 64'h0);
`endif
    step();
    send(1'b0, 16'h0013, 64'h0, 1'b0, 32'h0, "post_rst");
    finish_resp(32'h1111_4444, "post_rst");

    // Reset mid-WAIT discards an uncommitted write (LATENCY=4).
    drv(1'b1, 1'b0, 1'b1, 16'h0010, ALL_A);
    step();
    idle();
    step();
    #1;
    rst4_n = 1'b0;
    step();
    rst4_n = 1'b1;
    step();
    @(negedge clk);
    check("rst_no_rdy4", 64'(if4.mem_data_ready), 64'h0);
    step();
    drv(1'b1, 1'b0, 1'b0, 16'h0010, 64'h0);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    check("rst_old_rdy4", 64'(if4.mem_data_ready), 64'h1);
    check("rst_old_dat4", 64'(if4.mem_data_data), 64'h2222_1111);
    step();

    // Same with LATENCY=1: reset lands before the accept edge.
    drv(1'b0, 1'b1, 1'b1, 16'h0010, ALL_A);
    #1;
    rst1_n = 1'b0;
    step();
    rst1_n = 1'b1;
    idle();
    @(negedge clk);
    check("rst_no_rdy1", 64'(if1.mem_data_ready), 64'h0);
    step();
    drv(1'b0, 1'b1, 1'b0, 16'h0010, 64'h0);
    step();
    idle();
    @(negedge clk);
    check("rst_old_rdy1", 64'(if1.mem_data_ready), 64'h1);
    check("rst_old_dat1", 64'(if1.mem_data_data), 64'h2222_1111);
    step();

    // Random traffic over the preloaded lines; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 40)
        drv($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
            16'($urandom_range(0, 63)), {$urandom, $urandom});
      else
        idle();
      step();
    end
    idle();
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
